writeback_arbiter: RTL and testbench
====================================

// Module: writeback_arbiter
// PURPOSE
// Write-side master for the register file's single write port (write_en/write_id/write_data).
// Merges single-cycle pipeline results with multi-cycle unit results (load/div) into one write per cycle.
// Tracks in-flight multi-cycle destinations in a scoreboard, and gives decode a RAW hazard flag.
// PARAMETERS
// REG_COUNT     32  number of architectural registers; x0 is hard-wired zero
// DATA_W        32  result/data width
// FIFO_DEPTH    2   multi-cycle completion buffer entries (power of 2, >=2)
// STARVE_LIMIT  4   consecutive pipeline wins with FIFO non-empty before the FIFO is forced through
// PORTS
// clk            in   1       clock, all state on rising edge
// reset          in   1       synchronous, active-high reset
// pipe_wb_valid  in   1       single-cycle result present this cycle
// pipe_wb_id     in   5       destination register of pipeline result
// pipe_wb_data   in   DATA_W  pipeline result
// pipe_stall     out  1       pipeline result NOT accepted this cycle; upstream holds it
// mc_issue       in   1       multi-cycle op issued this cycle
// mc_issue_id    in   5       destination of issued multi-cycle op
// mc_issue_ready out  1       !pending[mc_issue_id] (combinational)
// mc_valid       in   1       multi-cycle completion offered
// mc_id          in   5       completion destination
// mc_data        in   DATA_W  completion data
// mc_ready       out  1       !fifo_full (combinational); transfer when mc_valid && mc_ready
// rs1_id,rs2_id  in   5 each  decode source registers
// hazard         out  1       pending[rs1_id] | pending[rs2_id] (combinational)
// issue_err      out  1       sticky: mc_issue seen while mc_issue_ready==0
// write_en       out  1       register-file write strobe (registered)
// write_id       out  5       register-file write address (registered)
// write_data     out  DATA_W  register-file write data (registered)
// BEHAVIOUR
// - Reset: write_en/write_id/write_data=0, issue_err=0, FIFO empty, pending all 0, starve_cnt=0.
// - Reset mid-operation discards FIFO contents and scoreboard.
// - Latency: result selected in cycle N appears on write_* in N+1, for exactly one cycle.
// - Winner select each cycle:
//   - forced = fifo_nonempty && starve_cnt==STARVE_LIMIT.
//   - Priority: forced FIFO head > pipe_wb_valid > FIFO head > none.
//   - pipe_stall = pipe_wb_valid && forced. Otherwise a pipeline result is always accepted.
// - starve_cnt:
//   - +1 when pipeline wins with FIFO non-empty (saturates at STARVE_LIMIT).
//   - Cleared when FIFO head is written or FIFO is empty.
// - Id 0: write to 0 is consumed (pipe accepted / FIFO popped) but write_en stays 0 next cycle.
// - FIFO: push on mc_valid&&mc_ready; pop when head selected.
//   - Push+pop on same cycle when full: not allowed (mc_ready is 0 when full, no lookahead).
//   - Push into empty FIFO is not selectable until next cycle: no input-to-write bypass.
// - Scoreboard pending[REG_COUNT]:
//   - Set on mc_issue with id!=0 and mc_issue_ready.
//   - Cleared when a FIFO entry with that id is selected.
//   - Set and clear on same id in same cycle: set wins.
//   - pending[0] is constant 0.
//   - mc_issue while !mc_issue_ready: ignored, issue_err<=1 until reset.
// - Pipeline write to a pending register is passed through unchanged (ordering is upstream's job).
// - mc_data/mc_id held stable by source while mc_valid && !mc_ready.
// TESTING
// - Pipe only: valid id=5 data=0xDEADBEEF at N -> write_en=1,id=5,data=0xDEADBEEF at N+1, 0 at N+2.
// - Scoreboard: issue id=7 -> hazard=1 for rs1=7.
//   - Completion id=7 data=0x12 -> written 2 cycles after handshake.
//   - hazard=0 the cycle after FIFO pop.
// - Collision: FIFO holds id=3 and pipe valid id=4 same cycle -> id=4 written first, id=3 next cycle.
// - Starvation: FIFO non-empty, pipe valid every cycle -> after 4 pipe wins, pipe_stall=1 one cycle.
//   - The FIFO entry is written, and the held pipe result is written the following cycle.
// - Backpressure: 2 completions without drain -> mc_ready=0; third held; accepted the cycle after a pop.
// - Edge: pipe id=0 -> no write_en.
//   - Re-issue of a pending id -> mc_issue_ready=0, issue_err=1.
//   - reset mid-FIFO -> FIFO empty, hazard=0.

Source files
------------

// File: rtl/writeback_arbiter.sv
// Single write-port master for the register file: merges pipeline results with
// buffered multi-cycle completions and tracks in-flight destinations for decode.
module writeback_arbiter #(
    parameter int REG_COUNT    = 32,
    parameter int DATA_W       = 32,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pipe_wb_valid,
    input  logic [4:0]        pipe_wb_id,
    input  logic [DATA_W-1:0] pipe_wb_data,
    output logic              pipe_stall,
    input  logic              mc_issue,
    input  logic [4:0]        mc_issue_id,
    output logic              mc_issue_ready,
    input  logic              mc_valid,
    input  logic [4:0]        mc_id,
    input  logic [DATA_W-1:0] mc_data,
    output logic              mc_ready,
    input  logic [4:0]        rs1_id,
    input  logic [4:0]        rs2_id,
    output logic              hazard,
    output logic              issue_err,
    output logic              write_en,
    output logic [4:0]        write_id,
    output logic [DATA_W-1:0] write_data
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [CW-1:0] FIFO_MAX   = CW'(FIFO_DEPTH);

    logic [4:0]        fifo_id   [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic [SW-1:0]     starve_cnt;
    logic [REG_COUNT-1:0] pending;
    logic [REG_COUNT-1:0] pending_nxt;

    logic fifo_nonempty;
    logic fifo_full;
    logic forced;
    logic sel_fifo;
    logic sel_pipe;
    logic push;
    logic issue_ok;
    logic [4:0]        head_id;
    logic [DATA_W-1:0] head_data;

    assign fifo_nonempty  = (count != '0);
    assign fifo_full      = (count == FIFO_MAX);
    assign head_id        = fifo_id[rd_ptr];
    assign head_data      = fifo_data[rd_ptr];
    assign forced         = fifo_nonempty && (starve_cnt == STARVE_MAX);
    assign sel_fifo       = fifo_nonempty && (forced || !pipe_wb_valid);
    assign sel_pipe       = pipe_wb_valid && !forced;
    assign pipe_stall     = pipe_wb_valid && forced;
    assign mc_ready       = !fifo_full;
    assign push           = mc_valid && mc_ready;
    assign mc_issue_ready = !pending[mc_issue_id];
    assign issue_ok       = mc_issue && mc_issue_ready && (mc_issue_id != 5'd0);
    assign hazard         = pending[rs1_id] | pending[rs2_id];

    // A new issue to the same id as the retiring head must leave it pending.
    always_comb begin
        pending_nxt = pending;
        if (sel_fifo) begin
            pending_nxt[head_id] = 1'b0;
        end
        if (issue_ok) begin
            pending_nxt[mc_issue_id] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_id[wr_ptr]   <= mc_id;
            fifo_data[wr_ptr] <= mc_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
            pending    <= '0;
            issue_err  <= 1'b0;
            write_en   <= 1'b0;
            write_id   <= '0;
            write_data <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (sel_fifo) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !sel_fifo) begin
                count <= count + CW'(1);
            end else if (!push && sel_fifo) begin
                count <= count - CW'(1);
            end

            if (sel_fifo || !fifo_nonempty) begin
                starve_cnt <= '0;
            end else if (sel_pipe && starve_cnt != STARVE_MAX) begin
                starve_cnt <= starve_cnt + SW'(1);
            end

            pending <= pending_nxt;
            if (mc_issue && !mc_issue_ready) begin
                issue_err <= 1'b1;
            end

            // Id 0 is consumed like any other result but never strobes the file.
            write_en <= 1'b0;
            if (sel_fifo) begin
                write_en   <= (head_id != 5'd0);
                write_id   <= head_id;
                write_data <= head_data;
            end else if (sel_pipe) begin
                write_en   <= (pipe_wb_id != 5'd0);
                write_id   <= pipe_wb_id;
                write_data <= pipe_wb_data;
            end
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: each task drives one scenario and
// compares the registered write port and handshake outputs with hand-derived values.
module tb_writeback_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_wb_valid;
    logic [4:0]  pipe_wb_id;
    logic [31:0] pipe_wb_data;
    logic        pipe_stall;
    logic        mc_issue;
    logic [4:0]  mc_issue_id;
    logic        mc_issue_ready;
    logic        mc_valid;
    logic [4:0]  mc_id;
    logic [31:0] mc_data;
    logic        mc_ready;
    logic [4:0]  rs1_id;
    logic [4:0]  rs2_id;
    logic        hazard;
    logic        issue_err;
    logic        write_en;
    logic [4:0]  write_id;
    logic [31:0] write_data;

    int tests  = 0;
    int failed = 0;

    writeback_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .pipe_wb_valid (pipe_wb_valid),
        .pipe_wb_id    (pipe_wb_id),
        .pipe_wb_data  (pipe_wb_data),
        .pipe_stall    (pipe_stall),
        .mc_issue      (mc_issue),
        .mc_issue_id   (mc_issue_id),
        .mc_issue_ready(mc_issue_ready),
        .mc_valid      (mc_valid),
        .mc_id         (mc_id),
        .mc_data       (mc_data),
        .mc_ready      (mc_ready),
        .rs1_id        (rs1_id),
        .rs2_id        (rs2_id),
        .hazard        (hazard),
        .issue_err     (issue_err),
        .write_en      (write_en),
        .write_id      (write_id),
        .write_data    (write_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pipe_wb_valid = 1'b0;
        pipe_wb_id    = '0;
        pipe_wb_data  = '0;
        mc_issue      = 1'b0;
        mc_issue_id   = '0;
        mc_valid      = 1'b0;
        mc_id         = '0;
        mc_data       = '0;
        rs1_id        = '0;
        rs2_id        = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        tests++; if (write_en !== 1'b0) begin failed++; $display("[TB] FAIL reset_write_en got %b want 0", write_en); end
        tests++; if (write_id !== 5'd0) begin failed++; $display("[TB] FAIL reset_write_id got %0d want 0", write_id); end
        tests++; if (write_data !== 32'd0) begin failed++; $display("[TB] FAIL reset_write_data got %h want 0", write_data); end
        tests++; if (issue_err !== 1'b0) begin failed++; $display("[TB] FAIL reset_issue_err got %b want 0", issue_err); end
        tests++; if (mc_ready !== 1'b1) begin failed++; $display("[TB] FAIL reset_mc_ready got %b want 1", mc_ready); end
        tests++; if (hazard !== 1'b0) begin failed++; $display("[TB] FAIL reset_hazard got %b want 0", hazard); end
    endtask

    task automatic test_pipe_only();
        pipe_wb_valid = 1'b1; pipe_wb_id = 5'd5; pipe_wb_data = 32'hDEADBEEF;
        #1;
        tests++; if (pipe_stall !== 1'b0) begin failed++; $display("[TB] FAIL pipe_stall got %b want 0", pipe_stall); end
        tick();
        pipe_wb_valid = 1'b0;
        tests++; if ({write_en, write_id, write_data} !== {1'b1, 5'd5, 32'hDEADBEEF})
            begin failed++; $display("[TB] FAIL pipe_write got en=%b id=%0d data=%h want en=1 id=5 data=deadbeef", write_en, write_id, write_data); end
        tick();
        tests++; if (write_en !== 1'b0) begin failed++; $display("[TB] FAIL pipe_single_cycle got %b want 0", write_en); end
    endtask

    task automatic test_scoreboard();
        mc_issue = 1'b1; mc_issue_id = 5'd7; rs1_id = 5'd7;
        #1;
        tests++; if (mc_issue_ready !== 1'b1) begin failed++; $display("[TB] FAIL sb_issue_ready got %b want 1", mc_issue_ready); end
        tick();
        mc_issue = 1'b0;
        #1;
        tests++; if (hazard !== 1'b1) begin failed++; $display("[TB] FAIL sb_hazard_set got %b want 1", hazard); end
        mc_valid = 1'b1; mc_id = 5'd7; mc_data = 32'h12;
        tick();
        mc_valid = 1'b0;
        tests++; if (write_en !== 1'b0) begin failed++; $display("[TB] FAIL sb_no_bypass got %b want 0", write_en); end
        tests++; if (hazard !== 1'b1) begin failed++; $display("[TB] FAIL sb_hazard_hold got %b want 1", hazard); end
        tick();
        tests++; if ({write_en, write_id, write_data} !== {1'b1, 5'd7, 32'h12})
            begin failed++; $display("[TB] FAIL sb_write got en=%b id=%0d data=%h want en=1 id=7 data=12", write_en, write_id, write_data); end
        tests++; if (hazard !== 1'b0) begin failed++; $display("[TB] FAIL sb_hazard_clear got %b want 0", hazard); end
        rs1_id = '0;
        tick();
    endtask

    task automatic test_collision();
        mc_issue = 1'b1; mc_issue_id = 5'd3;
        tick();
        mc_issue = 1'b0;
        mc_valid = 1'b1; mc_id = 5'd3; mc_data = 32'h33;
        tick();
        mc_valid = 1'b0;
        pipe_wb_valid = 1'b1; pipe_wb_id = 5'd4; pipe_wb_data = 32'h44;
        tick();
        pipe_wb_valid = 1'b0;
        tests++; if ({write_en, write_id, write_data} !== {1'b1, 5'd4, 32'h44})
            begin failed++; $display("[TB] FAIL coll_pipe_first got en=%b id=%0d data=%h want en=1 id=4 data=44", write_en, write_id, write_data); end
        tick();
        tests++; if ({write_en, write_id, write_data} !== {1'b1, 5'd3, 32'h33})
            begin failed++; $display("[TB] FAIL coll_fifo_next got en=%b id=%0d data=%h want en=1 id=3 data=33", write_en, write_id, write_data); end
        tick();
    endtask

    task automatic test_starvation();
        mc_issue = 1'b1; mc_issue_id = 5'd9;
        tick();
        mc_issue = 1'b0;
        mc_valid = 1'b1; mc_id = 5'd9; mc_data = 32'h99;
        tick();
        mc_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pipe_wb_valid = 1'b1; pipe_wb_id = 5'(10 + i); pipe_wb_data = 32'(32'hA0 + i);
            #1;
            tests++; if (pipe_stall !== 1'b0) begin failed++; $display("[TB] FAIL starve_win%0d_stall got %b want 0", i, pipe_stall); end
            tick();
            tests++; if ({write_en, write_id} !== {1'b1, 5'(10 + i)})
                begin failed++; $display("[TB] FAIL starve_win%0d got en=%b id=%0d want en=1 id=%0d", i, write_en, write_id, 10 + i); end
        end
        pipe_wb_id = 5'd14; pipe_wb_data = 32'hE;
        #1;
        tests++; if (pipe_stall !== 1'b1) begin failed++; $display("[TB] FAIL starve_forced_stall got %b want 1", pipe_stall); end
        tick();
        tests++; if ({write_en, write_id, write_data} !== {1'b1, 5'd9, 32'h99})
            begin failed++; $display("[TB] FAIL starve_fifo_write got en=%b id=%0d data=%h want en=1 id=9 data=99", write_en, write_id, write_data); end
        tests++; if (pipe_stall !== 1'b0) begin failed++; $display("[TB] FAIL starve_release got %b want 0", pipe_stall); end
        tick();
        pipe_wb_valid = 1'b0;
        tests++; if ({write_en, write_id, write_data} !== {1'b1, 5'd14, 32'hE})
            begin failed++; $display("[TB] FAIL starve_held_write got en=%b id=%0d data=%h want en=1 id=14 data=e", write_en, write_id, write_data); end
        tick();
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 3; i++) begin
            mc_issue = 1'b1; mc_issue_id = 5'(20 + i);
            tick();
        end
        mc_issue = 1'b0;
        pipe_wb_valid = 1'b1; pipe_wb_id = 5'd25; pipe_wb_data = 32'h25;
        mc_valid = 1'b1; mc_id = 5'd20; mc_data = 32'h200;
        tick();
        mc_id = 5'd21; mc_data = 32'h210;
        tick();
        tests++; if ({write_en, write_id} !== {1'b1, 5'd25})
            begin failed++; $display("[TB] FAIL bp_pipe_write got en=%b id=%0d want en=1 id=25", write_en, write_id); end
        mc_id = 5'd22; mc_data = 32'h220;
        #1;
        tests++; if (mc_ready !== 1'b0) begin failed++; $display("[TB] FAIL bp_full got %b want 0", mc_ready); end
        tick();
        tests++; if (mc_ready !== 1'b0) begin failed++; $display("[TB] FAIL bp_full_hold got %b want 0", mc_ready); end
        pipe_wb_valid = 1'b0;
        #1;
        tests++; if (mc_ready !== 1'b0) begin failed++; $display("[TB] FAIL bp_no_lookahead got %b want 0", mc_ready); end
        tick();
        tests++; if ({write_en, write_id, write_data} !== {1'b1, 5'd20, 32'h200})
            begin failed++; $display("[TB] FAIL bp_pop20 got en=%b id=%0d data=%h want en=1 id=20 data=200", write_en, write_id, write_data); end
        tests++; if (mc_ready !== 1'b1) begin failed++; $display("[TB] FAIL bp_ready_after_pop got %b want 1", mc_ready); end
        tick();
        mc_valid = 1'b0;
        tests++; if ({write_en, write_id, write_data} !== {1'b1, 5'd21, 32'h210})
            begin failed++; $display("[TB] FAIL bp_pop21 got en=%b id=%0d data=%h want en=1 id=21 data=210", write_en, write_id, write_data); end
        tick();
        tests++; if ({write_en, write_id, write_data} !== {1'b1, 5'd22, 32'h220})
            begin failed++; $display("[TB] FAIL bp_pop22 got en=%b id=%0d data=%h want en=1 id=22 data=220", write_en, write_id, write_data); end
        rs1_id = 5'd22; rs2_id = 5'd21;
        #1;
        tests++; if (hazard !== 1'b0) begin failed++; $display("[TB] FAIL bp_hazard_clear got %b want 0", hazard); end
        rs1_id = '0; rs2_id = '0;
        tick();
    endtask

    task automatic test_id_zero();
        pipe_wb_valid = 1'b1; pipe_wb_id = 5'd0; pipe_wb_data = 32'h55;
        #1;
        tests++; if (pipe_stall !== 1'b0) begin failed++; $display("[TB] FAIL id0_stall got %b want 0", pipe_stall); end
        tick();
        pipe_wb_valid = 1'b0;
        tests++; if (write_en !== 1'b0) begin failed++; $display("[TB] FAIL id0_write_en got %b want 0", write_en); end
        tick();
    endtask

    task automatic test_reissue();
        mc_issue = 1'b1; mc_issue_id = 5'd30;
        tick();
        #1;
        tests++; if (mc_issue_ready !== 1'b0) begin failed++; $display("[TB] FAIL reissue_ready got %b want 0", mc_issue_ready); end
        tests++; if (issue_err !== 1'b0) begin failed++; $display("[TB] FAIL reissue_err_early got %b want 0", issue_err); end
        tick();
        mc_issue = 1'b0;
        tests++; if (issue_err !== 1'b1) begin failed++; $display("[TB] FAIL reissue_err got %b want 1", issue_err); end
        tick();
        tests++; if (issue_err !== 1'b1) begin failed++; $display("[TB] FAIL reissue_err_sticky got %b want 1", issue_err); end
    endtask

    task automatic test_reset_mid();
        mc_issue = 1'b1; mc_issue_id = 5'd12;
        tick();
        mc_issue = 1'b0;
        mc_valid = 1'b1; mc_id = 5'd12; mc_data = 32'hC0C0;
        tick();
        mc_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rs1_id = 5'd12; rs2_id = 5'd30;
        #1;
        tests++; if (hazard !== 1'b0) begin failed++; $display("[TB] FAIL rstmid_hazard got %b want 0", hazard); end
        tests++; if (issue_err !== 1'b0) begin failed++; $display("[TB] FAIL rstmid_issue_err got %b want 0", issue_err); end
        tests++; if (mc_ready !== 1'b1) begin failed++; $display("[TB] FAIL rstmid_mc_ready got %b want 1", mc_ready); end
        tick();
        tests++; if (write_en !== 1'b0) begin failed++; $display("[TB] FAIL rstmid_fifo_empty got %b want 0", write_en); end
        rs1_id = '0; rs2_id = '0;
    endtask

    initial begin
        test_reset();
        test_pipe_only();
        test_scoreboard();
        test_collision();
        test_starvation();
        test_backpressure();
        test_id_zero();
        test_reissue();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
